// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with load-use hazard detection, EX operand forwarding
// selects and a saturating stall-cycle counter.
module id_ex_forward #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_alu_src,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_alu_src,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic [CNTW-1:0] stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            alu_src;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } idex_t;

    idex_t           idex_q, idex_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            hazard;

    always_comb begin
        hazard = id_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd0) &
                 ((idex_q.rd == id_rs1) | (idex_q.rd == id_rs2));
    end

    // Flush and stall both insert an all-zero bubble; flush has no extra effect.
    always_comb begin
        idex_d = '0;
        if (!(flush || hazard)) begin
            idex_d.valid     = id_valid;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
            idex_d.alu_src   = id_alu_src;
            idex_d.rs1       = id_rs1;
            idex_d.rs2       = id_rs2;
            idex_d.rd        = id_rd;
            idex_d.rs1_data  = id_rs1_data;
            idex_d.rs2_data  = id_rs2_data;
            idex_d.imm       = id_imm;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (idex_q.valid) begin
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == idex_q.rs1)) begin
                fwd_a_sel = 2'b01;
            end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == idex_q.rs1)) begin
                fwd_a_sel = 2'b10;
            end
            if (idex_q.alu_src) begin
                fwd_b_sel = 2'b11;
            end else if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == idex_q.rs2)) begin
                fwd_b_sel = 2'b01;
            end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == idex_q.rs2)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    assign stall        = hazard;
    assign ex_valid     = idex_q.valid;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_mem_read  = idex_q.mem_read;
    assign ex_alu_src   = idex_q.alu_src;
    assign ex_rs1       = idex_q.rs1;
    assign ex_rs2       = idex_q.rs2;
    assign ex_rd        = idex_q.rd;
    assign ex_rs1_data  = idex_q.rs1_data;
    assign ex_rs2_data  = idex_q.rs2_data;
    assign ex_imm       = idex_q.imm;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_forward.sv
// Directed-vector bench for id_ex_forward; stall counter narrowed so saturation is quick.
module tb_id_ex_forward;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            id_reg_write, id_mem_read, id_alu_src;
    logic            flush;
    logic [4:0]      mem_rd, wb_rd;
    logic            mem_reg_write, wb_reg_write;
    logic            stall;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_alu_src;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [1:0]      fwd_a_sel, fwd_b_sel;
    logic [CNTW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_forward #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_alu_src(id_alu_src),
        .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [XLEN-1:0] d1,
                          input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                          input logic rw, input logic mr, input logic as);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_alu_src = as;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0, 1'b0);
        step();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h exp 0", ex_valid); end
        tests++; if (ex_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0h exp 0", ex_rd); end
        tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0h exp 0", stall_cnt); end
        tests++; if ({stall, fwd_a_sel, fwd_b_sel} !== 5'b0) begin fails++; $display("FAIL reset_comb got %0h exp 0", {stall, fwd_a_sel, fwd_b_sel}); end
        #2 rst_n = 1'b1;
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_release_async got %0h exp 0", ex_valid); end
    endtask

    task automatic test_load();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hDEAD_0001, 32'hBEEF_0002, 32'h0000_0FFC, 1'b1, 1'b0, 1'b0);
        step();
        tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL load_valid got %0h exp 1", ex_valid); end
        tests++; if ({ex_rs1, ex_rs2, ex_rd} !== {5'd1, 5'd2, 5'd3}) begin fails++; $display("FAIL load_idx got %0h exp %0h", {ex_rs1, ex_rs2, ex_rd}, {5'd1, 5'd2, 5'd3}); end
        tests++; if (ex_rs1_data !== 32'hDEAD_0001) begin fails++; $display("FAIL load_d1 got %0h exp DEAD0001", ex_rs1_data); end
        tests++; if (ex_rs2_data !== 32'hBEEF_0002) begin fails++; $display("FAIL load_d2 got %0h exp BEEF0002", ex_rs2_data); end
        tests++; if (ex_imm !== 32'h0000_0FFC) begin fails++; $display("FAIL load_imm got %0h exp FFC", ex_imm); end
        tests++; if ({ex_reg_write, ex_mem_read, ex_alu_src} !== 3'b100) begin fails++; $display("FAIL load_ctrl got %0b exp 100", {ex_reg_write, ex_mem_read, ex_alu_src}); end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 32'h8, 1'b1, 1'b1, 1'b1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_pre_stall got %0h exp 0", stall); end
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 32'hA, 32'hB, 32'h0, 1'b1, 1'b0, 1'b0);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %0h exp 1", stall); end
        step();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %0h exp 0", ex_valid); end
        tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_cnt got %0h exp 1", stall_cnt); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_clear got %0h exp 0", stall); end
        step();
        tests++; if ({ex_valid, ex_rd, ex_rs1} !== {1'b1, 5'd6, 5'd5}) begin fails++; $display("FAIL lu_reenter got %0h exp %0h", {ex_valid, ex_rd, ex_rs1}, {1'b1, 5'd6, 5'd5}); end
        // Load to x0 followed by a reader of x0 must not stall.
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_x0 got %0h exp 0", stall); end
    endtask

    task automatic test_forward();
        set_id(1'b1, 5'd7, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1; #1;
        tests++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL fwd_a_both got %0b exp 01", fwd_a_sel); end
        mem_reg_write = 1'b0; #1;
        tests++; if (fwd_a_sel !== 2'b10) begin fails++; $display("FAIL fwd_a_wb got %0b exp 10", fwd_a_sel); end
        wb_reg_write = 1'b0; #1;
        tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL fwd_a_none got %0b exp 00", fwd_a_sel); end
        mem_rd = 5'd8; mem_reg_write = 1'b1; #1;
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin fails++; $display("FAIL fwd_b_mem got %0b exp 0001", {fwd_a_sel, fwd_b_sel}); end
        mem_reg_write = 1'b0; wb_rd = 5'd8; wb_reg_write = 1'b1; #1;
        tests++; if (fwd_b_sel !== 2'b10) begin fails++; $display("FAIL fwd_b_wb got %0b exp 10", fwd_b_sel); end
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; #1;
    endtask

    task automatic test_x0_imm();
        set_id(1'b1, 5'd4, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1; #1;
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin fails++; $display("FAIL x0_nofwd got %0b exp 0000", {fwd_a_sel, fwd_b_sel}); end
        set_id(1'b1, 5'd4, 5'd0, 5'd2, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0, 1'b1);
        step();
        tests++; if (fwd_b_sel !== 2'b11) begin fails++; $display("FAIL imm_sel got %0b exp 11", fwd_b_sel); end
        mem_rd = 5'd4; #1;
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0111) begin fails++; $display("FAIL imm_a_mem got %0b exp 0111", {fwd_a_sel, fwd_b_sel}); end
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; #1;
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h77, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if ({ex_valid, ex_reg_write, ex_alu_src, ex_rd} !== 8'd0) begin fails++; $display("FAIL flush_bubble got %0h exp 0", {ex_valid, ex_reg_write, ex_alu_src, ex_rd}); end
        tests++; if ({ex_rs1_data, ex_imm} !== 64'd0) begin fails++; $display("FAIL flush_data got %0h exp 0", {ex_rs1_data, ex_imm}); end
        // ex_valid=0 with matching MEM write: no forwarding
        mem_rd = 5'd1; mem_reg_write = 1'b1; #1;
        tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL invalid_nofwd got %0b exp 00", fwd_a_sel); end
        mem_reg_write = 1'b0;
        // flush together with a load-use hazard
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 5'd10, 5'd11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1; #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_stall_out got %0h exp 1", stall); end
        step();
        flush = 1'b0;
        tests++; if ({ex_valid, stall_cnt} !== {1'b0, 4'd2}) begin fails++; $display("FAIL flush_stall_cnt got %0h exp %0h", {ex_valid, stall_cnt}, {1'b0, 4'd2}); end
    endtask

    task automatic test_async_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd12, 5'd0, 5'd13, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tests++; if ({ex_valid, stall} !== 2'b11) begin fails++; $display("FAIL ar_setup got %0b exp 11", {ex_valid, stall}); end
        #2 rst_n = 1'b0; #1;
        tests++; if ({ex_valid, stall, ex_mem_read, ex_rd} !== 8'd0) begin fails++; $display("FAIL ar_clear got %0h exp 0", {ex_valid, stall, ex_mem_read, ex_rd}); end
        tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL ar_cnt got %0h exp 0", stall_cnt); end
        #2 rst_n = 1'b1;
        step();
        tests++; if ({ex_valid, ex_rd, stall_cnt} !== {1'b1, 5'd13, 4'd0}) begin fails++; $display("FAIL ar_first_capture got %0h exp %0h", {ex_valid, ex_rd, stall_cnt}, {1'b1, 5'd13, 4'd0}); end
    endtask

    task automatic test_saturation();
        logic [CNTW-1:0] exp_cnt;
        logic            exp_stall;
        exp_cnt = '0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        set_id(1'b1, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_stall = (i % 2) == 1;
            tests++; if (stall !== exp_stall) begin fails++; $display("FAIL sat_stall[%0d] got %0h exp %0h", i, stall, exp_stall); end
            step();
            if (exp_stall && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
            tests++; if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL sat_cnt[%0d] got %0h exp %0h", i, stall_cnt, exp_cnt); end
        end
        tests++; if (stall_cnt !== 4'hF) begin fails++; $display("FAIL sat_final got %0h exp F", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_use();
        test_forward();
        test_x0_imm();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
